// File: rtl/bcam_lookup_arb.sv
//----------------------------------------------------------------------------
// bcam_lookup_arb
//
// Round-robin arbiter that shares one binary CAM between NREQ requesters.
// One lookup is in flight at a time: a request is granted in IDLE, the
// latched key is strobed into the CAM for one cycle (ISSUE), the match result
// is collected after CAM_LAT cycles (WAIT), and the result is held for the
// granted requester until it accepts it (RESP).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. req_valid may be dropped or changed at any time and is never
// required to wait for req_ready. resp_valid stays high, with resp_hit and
// resp_addr stable, until the matching resp_ready bit is seen.
//
// Optional feature (compile-time macro BCAM_ARB_STATS_EN): adds saturating
// 32-bit hit/miss counters, one count per completed response handshake.
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   req_valid/ready  per-requester request handshake (req_ready one-hot)
//   req_key          packed keys, requester i at [i*MEMLEN +: MEMLEN]
//   resp_valid/ready per-requester response handshake (resp_valid one-hot)
//   resp_hit/addr    lookup result, addr is the 0-based CAM index, 0 on miss
//   cam_match_en     one-cycle CAM match strobe, cam_data_in = key
//   cam_match        CAM hit flag, cam_match_addr = hit index plus one
//   dbg_state        current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   stat_hits/misses (BCAM_ARB_STATS_EN only) response counters
//----------------------------------------------------------------------------
`timescale 1ns/1ps
module bcam_lookup_arb #(
  parameter int NREQ     = 4,
  parameter int MEMLEN   = 32,
  parameter int MEMDBITS = 9,
  parameter int CAM_LAT  = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*MEMLEN-1:0]   req_key,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          resp_valid,
  input  logic [NREQ-1:0]          resp_ready,
  output logic                     resp_hit,
  output logic [MEMDBITS-1:0]      resp_addr,
  output logic                     cam_match_en,
  output logic [MEMLEN-1:0]        cam_data_in,
  input  logic                     cam_match,
  input  logic [MEMDBITS-1:0]      cam_match_addr,
  output logic [1:0]               dbg_state
`ifdef BCAM_ARB_STATS_EN
  ,
  output logic [31:0]              stat_hits,
  output logic [31:0]              stat_misses
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(CAM_LAT + 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state;
  logic [IW-1:0]     ptr;      // first requester considered at next grant
  logic [IW-1:0]     gnt_q;    // requester owning the in-flight lookup
  logic [MEMLEN-1:0] key_q;
  logic [CW-1:0]     cnt;

  logic              found;
  logic [IW-1:0]     gidx;
  logic [MEMLEN-1:0] gkey;
  logic              accept;
  logic              resp_done;
  int                idx;
  logic [IW-1:0]     idx_w;

  assign dbg_state = state;

  // Round-robin search: scan requesters starting at ptr, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    idx_w = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IW'(idx);
      if (!found && req_valid[idx_w]) begin
        found = 1'b1;
        gidx  = idx_w;
      end
    end
  end

  always_comb begin
    gkey = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == gidx) gkey = req_key[i*MEMLEN +: MEMLEN];
    end
  end

  assign accept    = (state == IDLE) && found;
  assign resp_done = (state == RESP) && resp_ready[gnt_q];

  // Gated with resetn so req_ready drops the moment reset is asserted even
  // while requests are still being presented.
  always_comb begin
    req_ready = '0;
    if (resetn && accept) req_ready[gidx] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (state == RESP) resp_valid[gnt_q] = 1'b1;
  end

  assign cam_match_en = (state == ISSUE);
  assign cam_data_in  = (state == ISSUE) ? key_q : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_q     <= '0;
      key_q     <= '0;
      cnt       <= '0;
      resp_hit  <= 1'b0;
      resp_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            key_q <= gkey;
            gnt_q <= gidx;
            ptr   <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // The CAM registers the strobe on the ISSUE->WAIT edge; its result
          // is taken CAM_LAT cycles after the first WAIT cycle, which puts
          // the first resp_valid cycle 2+CAM_LAT edges after the accept.
          if (cnt == CW'(CAM_LAT)) begin
            resp_hit  <= cam_match;
            resp_addr <= cam_match ? (cam_match_addr - MEMDBITS'(1)) : '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (resp_done) begin
      if (resp_hit) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bcam_lookup_arb.sv
`timescale 1ns/1ps
module tb_bcam_lookup_arb;

  logic         clk;
  logic         resetn;
  logic [3:0]   req_valid;
  logic [127:0] req_key;
  logic [3:0]   req_ready;
  logic [3:0]   resp_valid;
  logic [3:0]   resp_ready;
  logic         resp_hit;
  logic [8:0]   resp_addr;
  logic         cam_match_en;
  logic [31:0]  cam_data_in;
  logic         cam_match;
  logic [8:0]   cam_match_addr;
  logic [1:0]   dbg_state;
`ifdef BCAM_ARB_STATS_EN
  logic [31:0]  stat_hits;
  logic [31:0]  stat_misses;
`endif

  int checks = 0;
  int errors = 0;

  bcam_lookup_arb #(.NREQ(4), .MEMLEN(32), .MEMDBITS(9), .CAM_LAT(1)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .req_valid      (req_valid),
    .req_key        (req_key),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_hit       (resp_hit),
    .resp_addr      (resp_addr),
    .cam_match_en   (cam_match_en),
    .cam_data_in    (cam_data_in),
    .cam_match      (cam_match),
    .cam_match_addr (cam_match_addr),
    .dbg_state      (dbg_state)
`ifdef BCAM_ARB_STATS_EN
    ,
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- CAM model (latency 1, result held until next strobe) ----
  logic [31:0] cam_tab [0:7];
  initial begin
    for (int i = 0; i < 8; i++) cam_tab[i] = 32'hFFFF_0000 + i;
    cam_tab[0] = 32'h0000_000A;
    cam_tab[1] = 32'h0000_0055;
    cam_tab[5] = 32'h1234_5678;
  end

  function automatic logic [9:0] cam_search(input logic [31:0] k);
    logic [9:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (cam_tab[i] == k) r = {1'b1, 9'(i + 1)};
    end
    return r;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cam_match      <= 1'b0;
      cam_match_addr <= '0;
    end else if (cam_match_en) begin
      {cam_match, cam_match_addr} <= cam_search(cam_data_in);
    end
  end

  // ---------------- driver tasks ----------------
  // Called mid-cycle with the DUT idle; returns what it observed.
  task automatic drive_lookup(input int r, input logic [31:0] key,
                              output logic [3:0] rdy, output int en_cycles,
                              output logic [31:0] data_seen, output int lat,
                              output logic [3:0] rv, output logic hit,
                              output logic [8:0] addr);
    req_valid[r] = 1'b1;
    req_key[r*32 +: 32] = key;
    #1;
    rdy = req_ready;
    @(posedge clk); #1;
    // Withdraw and scramble the request; the in-flight lookup must not care.
    req_valid[r] = 1'b0;
    req_key[r*32 +: 32] = $urandom;
    lat = 0; en_cycles = 0; data_seen = '0;
    while (resp_valid == 4'b0 && lat < 20) begin
      if (cam_match_en) begin
        en_cycles++;
        data_seen = cam_data_in;
      end
      @(posedge clk); #1;
      lat++;
    end
    rv = resp_valid; hit = resp_hit; addr = resp_addr;
    resp_ready[r] = 1'b1;
    @(posedge clk); #1;
    resp_ready[r] = 1'b0;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (resp_valid == 4'b0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (resp_valid !== 4'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0000", resp_valid); end
    checks++; if (resp_hit !== 1'b0) begin errors++; $display("FAIL reset_resp_hit: got %b expected 0", resp_hit); end
    checks++; if (resp_addr !== 9'd0) begin errors++; $display("FAIL reset_resp_addr: got %0d expected 0", resp_addr); end
    checks++; if (cam_match_en !== 1'b0) begin errors++; $display("FAIL reset_cam_match_en: got %b expected 0", cam_match_en); end
    checks++; if (cam_data_in !== 32'd0) begin errors++; $display("FAIL reset_cam_data_in: got %h expected 0", cam_data_in); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_hit();
    logic [3:0] rdy, rv; int en_c, lat; logic [31:0] dseen; logic hit; logic [8:0] addr;
    drive_lookup(0, 32'h0000_000A, rdy, en_c, dseen, lat, rv, hit, addr);
    checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL hit_grant: got %b expected 0001", rdy); end
    checks++; if (en_c !== 1) begin errors++; $display("FAIL hit_en_cycles: got %0d expected 1", en_c); end
    checks++; if (dseen !== 32'h0000_000A) begin errors++; $display("FAIL hit_cam_data: got %h expected 0000000a", dseen); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL hit_latency: got %0d expected 3", lat); end
    checks++; if (rv !== 4'b0001) begin errors++; $display("FAIL hit_resp_valid: got %b expected 0001", rv); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_flag: got %b expected 1", hit); end
    checks++; if (addr !== 9'd0) begin errors++; $display("FAIL hit_addr: got %0d expected 0", addr); end
    checks++; if (resp_valid !== 4'b0 || cam_match_en !== 1'b0 || cam_data_in !== 32'd0) begin
      errors++; $display("FAIL hit_after_idle: got rv=%b en=%b data=%h expected 0/0/0", resp_valid, cam_match_en, cam_data_in);
    end
  endtask

  task automatic test_miss();
    logic [3:0] rdy, rv; int en_c, lat; logic [31:0] dseen; logic hit; logic [8:0] addr;
    drive_lookup(2, 32'hDEAD_BEEF, rdy, en_c, dseen, lat, rv, hit, addr);
    checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL miss_grant: got %b expected 0100", rdy); end
    checks++; if (rv !== 4'b0100) begin errors++; $display("FAIL miss_resp_valid: got %b expected 0100", rv); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_flag: got %b expected 0", hit); end
    checks++; if (addr !== 9'd0) begin errors++; $display("FAIL miss_addr: got %0d expected 0", addr); end
`ifdef BCAM_ARB_STATS_EN
    checks++; if (stat_misses !== 32'd1) begin errors++; $display("FAIL stat_misses: got %0d expected 1", stat_misses); end
    checks++; if (stat_hits !== 32'd1) begin errors++; $display("FAIL stat_hits: got %0d expected 1", stat_hits); end
`endif
  endtask

  task automatic test_hit_addr();
    logic [3:0] rdy, rv; int en_c, lat; logic [31:0] dseen; logic hit; logic [8:0] addr;
    drive_lookup(3, 32'h1234_5678, rdy, en_c, dseen, lat, rv, hit, addr);
    checks++; if (rdy !== 4'b1000) begin errors++; $display("FAIL idx5_grant: got %b expected 1000", rdy); end
    checks++; if (hit !== 1'b1 || addr !== 9'd5) begin errors++; $display("FAIL idx5_result: got hit=%b addr=%0d expected hit=1 addr=5", hit, addr); end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int n = 0;
    int cyc = 0;
    logic [3:0] exp;
    req_key = {32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0055, 32'h0000_000A};
    resp_ready = 4'hF;
    req_valid  = 4'hF;
    #1;
    while (n < 5 && cyc < 60) begin
      if (req_ready !== 4'b0) begin
        exp = 4'b0001 << order[n];
        checks++;
        if ($countones(req_ready) != 1 || req_ready !== exp) begin
          errors++; $display("FAIL rr_grant_%0d: got %b expected %b", n, req_ready, exp);
        end
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_valid = 4'b0;
    checks++; if (n != 5) begin errors++; $display("FAIL rr_grant_count: got %0d expected 5", n); end
    repeat (6) @(posedge clk);
    #1;
    resp_ready = 4'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    req_key[32 +: 32] = 32'h0000_0055;
    req_key[0 +: 32]  = 32'h0000_000A;
    resp_ready = 4'b1101;             // other requesters' ready must be ignored
    req_valid  = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b expected 0010", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0001;               // competing request while busy
    wait_resp(cyc);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({resp_valid, resp_hit, resp_addr, req_ready} !== {4'b0010, 1'b1, 9'd1, 4'b0000}) begin
        errors++; $display("FAIL bp_hold_%0d: got rv=%b hit=%b addr=%0d rdy=%b expected rv=0010 hit=1 addr=1 rdy=0000",
                           i, resp_valid, resp_hit, resp_addr, req_ready);
      end
      @(posedge clk); #1;
    end
    req_valid  = 4'b0;
    resp_ready = 4'b0010;
    @(posedge clk); #1;
    resp_ready = 4'b0;
    checks++; if (resp_valid !== 4'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL bp_release: got rv=%b state=%0d expected rv=0000 state=0", resp_valid, dbg_state);
    end
  endtask

  task automatic test_reset_in_wait();
    int cyc;
    int seen;
    req_key[64 +: 32] = 32'h0000_000A;
    req_valid = 4'b0100;
    @(posedge clk); #1;                // accepted, now ISSUE
    req_valid = 4'b0;
    @(posedge clk); #1;                // now WAIT
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL rst_pre_state: got %0d expected 2", dbg_state); end
    req_valid = 4'b0010;
    #2;
    resetn = 1'b0;
    #1;
    checks++; if ({req_ready, resp_valid} !== 8'h00) begin errors++; $display("FAIL rst_async_handshake: got rdy=%b rv=%b expected 0000/0000", req_ready, resp_valid); end
    checks++; if ({resp_hit, resp_addr} !== 10'd0) begin errors++; $display("FAIL rst_async_result: got hit=%b addr=%0d expected 0/0", resp_hit, resp_addr); end
    checks++; if (cam_match_en !== 1'b0 || cam_data_in !== 32'd0) begin errors++; $display("FAIL rst_async_cam: got en=%b data=%h expected 0/0", cam_match_en, cam_data_in); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_async_state: got %0d expected 0", dbg_state); end
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b0;
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid !== 4'b0) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_no_resp: got %0d resp cycles expected 0", seen); end
    req_key   = {32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0055, 32'h0000_000A};
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0;
    wait_resp(cyc);
    checks++; if (resp_valid !== 4'b0001 || resp_hit !== 1'b1 || resp_addr !== 9'd0) begin
      errors++; $display("FAIL rst_first_resp: got rv=%b hit=%b addr=%0d expected 0001/1/0", resp_valid, resp_hit, resp_addr);
    end
    resp_ready = 4'b0001;
    @(posedge clk); #1;
    resp_ready = 4'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    resetn     = 1'b0;
    req_valid  = 4'b0;
    req_key    = '0;
    resp_ready = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    resetn = 1'b1;
    @(posedge clk); #1;
    test_hit();
    test_miss();
    test_hit_addr();
    test_round_robin();
    test_backpressure();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcam_lookup_arb.md
BCAM_LOOKUP_ARB -- requirements
Module: bcam_lookup_arb

Interface
REQ-001 SHALL have parameters, one per line:
  NREQ, 4, number of requesters
  MEMLEN, 32, key width
  MEMDBITS, 9, CAM address width
  CAM_LAT, 1, cycles from cam_match_en sample to valid cam_match
REQ-002 SHALL have ports, one per line:
  clk  in  1  single clock, all logic on posedge
  resetn  in  1  reset, asynchronous, active-low
  req_valid  in  NREQ  per-requester lookup request
  req_key  in  NREQ*MEMLEN  keys; requester i at bits [i*MEMLEN +: MEMLEN]
  req_ready  out  NREQ  one-hot grant; request accepted when req_valid[i]&req_ready[i]
  resp_valid  out  NREQ  one-hot response valid
  resp_ready  in  NREQ  per-requester response accept
  resp_hit  out  1  key found
  resp_addr  out  MEMDBITS  matching CAM index (0-based); 0 on miss
  cam_match_en  out  1  CAM match strobe
  cam_data_in  out  MEMLEN  key to CAM
  cam_match  in  1  CAM hit flag
  cam_match_addr  in  MEMDBITS  CAM reports hit index plus one

Function
REQ-003 SHALL use FSM states IDLE, ISSUE, WAIT, RESP.
REQ-004 IDLE: if any req_valid, SHALL select the granted requester round-robin, starting at the index after the last granted one (requester 0 first after reset); SHALL assert req_ready for that requester only, combinationally, in the same cycle; SHALL latch key and requester index; SHALL go to ISSUE.
REQ-005 req_ready SHALL be 0 in every state except IDLE; at most one req_ready bit SHALL be set.
REQ-006 ISSUE: SHALL assert cam_match_en=1 with cam_data_in=latched key for exactly one cycle; SHALL go to WAIT.
REQ-007 WAIT: SHALL count CAM_LAT cycles, then sample cam_match/cam_match_addr on that edge; SHALL go to RESP.
REQ-008 Lookup latency SHALL be 2+CAM_LAT cycles, measured from accept edge to first resp_valid cycle.
REQ-009 On hit, resp_addr SHALL be cam_match_addr-1 (MEMDBITS-bit arithmetic). On miss, resp_addr SHALL be 0 and resp_hit SHALL be 0.
REQ-010 RESP: SHALL hold resp_valid[granted]=1 and resp_hit/resp_addr stable until resp_ready[granted]=1; SHALL then return to IDLE. resp_ready bits of other requesters SHALL be ignored.
REQ-011 The round-robin pointer SHALL advance only on accept; it SHALL wrap from NREQ-1 to 0.
REQ-012 Outside ISSUE, cam_match_en SHALL be 0 and cam_data_in SHALL be 0.
REQ-013 Withdrawn or changed req_valid/req_key after accept SHALL not affect the in-flight lookup.
REQ-014 At most one lookup SHALL be in flight; no request SHALL be accepted between accept and response handshake.

Reset
REQ-015 On resetn low, asynchronously: state=IDLE, pointer=0, and req_ready, resp_valid, resp_hit, resp_addr, cam_match_en, cam_data_in all 0.
REQ-016 Reset in any state SHALL abort the lookup with no response; after release, the first grant SHALL follow REQ-004 from pointer 0.

Configuration
REQ-017 Macro BCAM_ARB_STATS_EN: when defined, the block SHALL add outputs stat_hits (32) and stat_misses (32). Each SHALL increment once per completed response handshake, per resp_hit, saturating at all-ones, and reset to 0. When undefined, these ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-018 CAM model with key 0x0000000A at index 0, CAM_LAT=1. Single request, req 0 key 0x0000000A -> resp_valid[0] 3 cycles after accept, resp_hit=1, resp_addr=0.
REQ-019 Req 2 key 0xDEADBEEF, key not present -> resp_hit=0, resp_addr=0; stats build: stat_misses=1.
REQ-020 All four req_valid held high continuously, resp_ready tied 1 -> grants in order 0,1,2,3,0; exactly one req_ready bit per accept.
REQ-021 resp_ready[1] held low 5 cycles during req 1 response -> resp_valid/resp_addr stable for 5 cycles; req_ready stays 0; then returns to IDLE.
REQ-022 resetn pulsed low during WAIT -> all outputs 0 immediately (before next clk edge); no resp_valid afterwards; next grant goes to requester 0.
